capa_comandos: RTL

Command-layer sequencer directly upstream of the CMD physical layer in the SD host. It accepts a command request (index, argument, response expectation), frames it into the 40-bit command word, and runs the strobe/ack handshake with the physical layer. It then collects the 15-bit response or timeout indication, retries timed-out commands up to a limit, and reports completion to the host register side. A watchdog aborts the physical layer if it never answers.

---
 rtl/capa_comandos_pkg.sv | 29 ++
 rtl/capa_comandos_if.sv | 25 ++
 rtl/capa_comandos_contador_watchdog.sv | 33 +++
 rtl/capa_comandos.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/capa_comandos_pkg.sv
// Shared definitions for the SD command layer: FSM encoding, frame widths and
// the 40-bit command framing helper used by the command and physical layers.
package capa_comandos_pkg;

    localparam int CMD_WIDTH   = 40;
    localparam int RESP_WIDTH  = 15;
    localparam int INDEX_WIDTH = 6;
    localparam int ARG_WIDTH   = 32;

    localparam logic START_BIT = 1'b0;
    localparam logic TX_BIT    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_ACK       = 3'd3,
        ST_ABORT     = 3'd4,
        ST_DONE      = 3'd5
    } estado_t;

    function automatic logic [CMD_WIDTH-1:0] build_cmd(
        input logic [INDEX_WIDTH-1:0] index,
        input logic [ARG_WIDTH-1:0]   argument
    );
        return {START_BIT, TX_BIT, index, argument};
    endfunction

endpackage

// File: rtl/capa_comandos_if.sv
// Channel between the command layer (master) and the CMD physical layer (slave).
interface capa_comandos_if;
    import capa_comandos_pkg::*;

    logic [CMD_WIDTH-1:0]  cmd_to_send;
    logic                  strobe_out;
    logic                  ack_out;
    logic                  idle_out;
    logic                  no_response;
    logic                  ack_in;
    logic                  strobe_in;
    logic [RESP_WIDTH-1:0] response;
    logic                  command_timeout;

    modport master (
        output cmd_to_send, strobe_out, ack_out, idle_out, no_response,
        input  ack_in, strobe_in, response, command_timeout
    );

    modport slave (
        input  cmd_to_send, strobe_out, ack_out, idle_out, no_response,
        output ack_in, strobe_in, response, command_timeout
    );

endinterface

// File: rtl/capa_comandos_contador_watchdog.sv
// Saturating cycle counter bounding how long the command layer waits for
// the physical layer to report a result.
module contador_watchdog #(
    parameter int WATCHDOG_CYCLES = 256
) (
    input  logic sd_clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WATCHDOG_CYCLES);

    logic [CW-1:0] count_r;

    assign expired = (count_r >= LIMIT);

    // Count enabled cycles, holding at the limit once reached.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && !expired) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/capa_comandos.sv
// Command-layer sequencer: frames host requests, handshakes with the CMD
// physical layer, collects responses, retries timeouts and reports completion.
module capa_comandos
    import capa_comandos_pkg::*;
#(
    parameter int MAX_RETRIES     = 2,
    parameter int WATCHDOG_CYCLES = 256
) (
    input  logic                   sd_clock,
    input  logic                   reset,
    input  logic                   new_command,
    input  logic [INDEX_WIDTH-1:0] cmd_index,
    input  logic [ARG_WIDTH-1:0]   cmd_argument,
    input  logic                   no_response_req,
    output logic                   busy,
    output logic                   cmd_complete,
    output logic                   timeout_error,
    output logic [RESP_WIDTH-1:0]  response_out,
    capa_comandos_if.master        phy
);

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    estado_t              state_r;
    logic [RW-1:0]        retry_count_r;
    logic                 timeout_seen_r;
    logic [CMD_WIDTH-1:0] cmd_word_r;
    logic                 no_resp_r;
    logic                 strobe_r;
    logic                 ack_r;
    logic                 idle_r;
    logic                 retry_ok_s;
    logic                 wd_clear_s;
    logic                 wd_enable_s;
    logic                 wd_expired_s;

    assign retry_ok_s  = (retry_count_r < RETRY_LIMIT);
    assign wd_enable_s = (state_r == ST_WAIT_RESP);
    assign wd_clear_s  = !wd_enable_s;

    assign phy.cmd_to_send = cmd_word_r;
    assign phy.strobe_out  = strobe_r;
    assign phy.ack_out     = ack_r;
    assign phy.idle_out    = idle_r;
    assign phy.no_response = no_resp_r;

    contador_watchdog #(
        .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_watchdog (
        .sd_clock(sd_clock),
        .reset   (reset),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );

    // Command sequencer with every output registered alongside the state.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            busy           <= 1'b0;
            cmd_complete   <= 1'b0;
            timeout_error  <= 1'b0;
            response_out   <= {RESP_WIDTH{1'b0}};
            cmd_word_r     <= {CMD_WIDTH{1'b0}};
            no_resp_r      <= 1'b0;
            strobe_r       <= 1'b0;
            ack_r          <= 1'b0;
            idle_r         <= 1'b1;
            retry_count_r  <= {RW{1'b0}};
            timeout_seen_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (new_command) begin
                        cmd_word_r     <= build_cmd(cmd_index, cmd_argument);
                        no_resp_r      <= no_response_req;
                        retry_count_r  <= {RW{1'b0}};
                        response_out   <= {RESP_WIDTH{1'b0}};
                        timeout_error  <= 1'b0;
                        timeout_seen_r <= 1'b0;
                        busy           <= 1'b1;
                        strobe_r       <= 1'b1;
                        idle_r         <= 1'b0;
                        state_r        <= ST_SEND;
                    end else begin
                        idle_r <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (phy.ack_in) begin
                        strobe_r <= 1'b0;
                        state_r  <= ST_WAIT_RESP;
                    end else begin
                        strobe_r <= 1'b1;
                    end
                end
                ST_WAIT_RESP: begin
                    // A result arriving in the expiry cycle still wins.
                    if (phy.strobe_in) begin
                        response_out   <= (no_resp_r || phy.command_timeout) ?
                                          {RESP_WIDTH{1'b0}} : phy.response;
                        timeout_seen_r <= phy.command_timeout;
                        ack_r          <= 1'b1;
                        state_r        <= ST_ACK;
                    end else if (wd_expired_s) begin
                        idle_r   <= 1'b1;
                        strobe_r <= 1'b0;
                        ack_r    <= 1'b0;
                        state_r  <= ST_ABORT;
                    end else begin
                        ack_r <= 1'b0;
                    end
                end
                ST_ACK: begin
                    if (phy.strobe_in) begin
                        ack_r <= 1'b1;
                    end else begin
                        ack_r <= 1'b0;
                        if (!timeout_seen_r) begin
                            cmd_complete <= 1'b1;
                            state_r      <= ST_DONE;
                        end else if (retry_ok_s) begin
                            retry_count_r <= retry_count_r + RW'(1);
                            strobe_r      <= 1'b1;
                            state_r       <= ST_SEND;
                        end else begin
                            timeout_error <= 1'b1;
                            cmd_complete  <= 1'b1;
                            state_r       <= ST_DONE;
                        end
                    end
                end
                ST_ABORT: begin
                    idle_r <= 1'b0;
                    if (retry_ok_s) begin
                        retry_count_r <= retry_count_r + RW'(1);
                        strobe_r      <= 1'b1;
                        state_r       <= ST_SEND;
                    end else begin
                        timeout_error <= 1'b1;
                        cmd_complete  <= 1'b1;
                        state_r       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cmd_complete <= 1'b0;
                    busy         <= 1'b0;
                    idle_r       <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    cmd_complete <= 1'b0;
                    busy         <= 1'b0;
                    strobe_r     <= 1'b0;
                    ack_r        <= 1'b0;
                    idle_r       <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
